// File: rtl/serdes_link_ctrl_if.sv
// Parallel-side bundle between the link controller and the SERDES pair / upstream user.
// The master modport is the controller; the slave modport is the SERDES/user side.
interface serdes_link_ctrl_if;
  localparam int unsigned WORD_W = 10;

  logic [WORD_W-1:0] rx_word;
  logic              RXPOL;
  logic [WORD_W-1:0] rx_data;
  logic              rx_word_valid;
  logic              sync;
  logic [WORD_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_load;
  logic [WORD_W-1:0] tx_word;

  modport master (
    input  rx_word, tx_data, tx_valid,
    output RXPOL, rx_data, rx_word_valid, sync, tx_ready, tx_load, tx_word
  );

  modport slave (
    output rx_word, tx_data, tx_valid,
    input  RXPOL, rx_data, rx_word_valid, sync, tx_ready, tx_load, tx_word
  );
endinterface

// File: rtl/serdes_link_ctrl.sv
// 10-bit SERDES link controller: TX word-slot timing plus RX comma alignment and sync tracking.
// Optional SERDES_AUTOPOL_EN: flips RXPOL after HUNT_TMO fruitless HUNT cycles.
module serdes_link_ctrl #(
  parameter logic [9:0]  COMMA      = 10'b0011111010,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned LOSS_CNT   = 4,
  parameter logic        RXPOL_INIT = 1'b1
`ifdef SERDES_AUTOPOL_EN
  ,
  parameter int unsigned HUNT_TMO   = 1023
`endif
) (
  input  logic                TRANSCLK,
  input  logic                RESET,
  input  logic                ENABLE,
  serdes_link_ctrl_if.master  link
);

  localparam int unsigned WORD_W  = 10;
  localparam int unsigned PHASE_W = 4;
  localparam int unsigned CNT_W   = 4;
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    SYNC   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PHASE_W-1:0]  rx_phase_q, rx_phase_d;
  logic [PHASE_W-1:0]  tx_phase_q, tx_phase_d;
  logic [CNT_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [WORD_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                sync_q, sync_d;
  logic                tx_load_q, tx_load_d;
  logic [WORD_W-1:0]   tx_word_q, tx_word_d;
  logic                is_comma, boundary, tx_slot, tx_ready_c;

`ifdef SERDES_AUTOPOL_EN
  localparam int unsigned TMO_W = $clog2(HUNT_TMO + 1);
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                rxpol_q, rxpol_d;
`endif

  assign is_comma   = (link.rx_word == COMMA);
  assign boundary   = (rx_phase_q == LAST_PHASE);
  assign tx_slot    = (tx_phase_q == LAST_PHASE);
  assign tx_ready_c = tx_slot && sync_q;

  // FSM and alignment counters
  always_ff @(posedge TRANSCLK) begin
    if (RESET) begin
      state_q    <= HUNT;
      rx_phase_q <= '0;
      lock_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rx_phase_q <= rx_phase_d;
      lock_cnt_q <= lock_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Next state: comma acquisition, lock verification and loss detection
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    err_cnt_d  = err_cnt_q;
    rx_phase_d = boundary ? '0 : rx_phase_q + PHASE_W'(1);
    case (state_q)
      HUNT: begin
        if (is_comma) begin
          rx_phase_d = '0;
          lock_cnt_d = CNT_W'(1);
          state_d    = VERIFY;
        end
      end
      VERIFY: begin
        if (boundary && is_comma) begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
          if (lock_cnt_d >= CNT_W'(LOCK_CNT)) state_d = SYNC;
        end else if (boundary || is_comma) begin
          lock_cnt_d = '0;
          state_d    = HUNT;
        end
      end
      SYNC: begin
        if (is_comma) begin
          if (boundary) begin
            err_cnt_d = '0;
          end else if (err_cnt_q + CNT_W'(1) >= CNT_W'(LOSS_CNT)) begin
            err_cnt_d  = '0;
            lock_cnt_d = '0;
            state_d    = HUNT;
          end else begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = HUNT;
    endcase
    if (!ENABLE) begin
      state_d    = HUNT;
      lock_cnt_d = '0;
      err_cnt_d  = '0;
    end
  end

  // Output next values: RX delivery and the free-running TX slot
  always_comb begin
    tx_phase_d = tx_slot ? '0 : tx_phase_q + PHASE_W'(1);
    tx_load_d  = tx_slot;
    tx_word_d  = tx_word_q;
    if (tx_slot) tx_word_d = (link.tx_valid && tx_ready_c) ? link.tx_data : COMMA;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    if ((state_q == SYNC) && boundary) begin
      rx_data_d  = link.rx_word;
      rx_valid_d = 1'b1;
    end
    sync_d = (state_d == SYNC);
  end

  always_ff @(posedge TRANSCLK) begin
    if (RESET) begin
      tx_phase_q <= '0;
      tx_load_q  <= 1'b0;
      tx_word_q  <= COMMA;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sync_q     <= 1'b0;
    end else begin
      tx_phase_q <= tx_phase_d;
      tx_load_q  <= tx_load_d;
      tx_word_q  <= tx_word_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sync_q     <= sync_d;
    end
  end

`ifdef SERDES_AUTOPOL_EN
  // A HUNT that sees no comma for HUNT_TMO cycles is assumed to be an inverted line
  always_comb begin
    tmo_cnt_d = '0;
    rxpol_d   = rxpol_q;
    if (ENABLE && (state_q == HUNT) && !is_comma) begin
      if (tmo_cnt_q == TMO_W'(HUNT_TMO - 1)) rxpol_d = ~rxpol_q;
      else tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge TRANSCLK) begin
    if (RESET) begin
      tmo_cnt_q <= '0;
      rxpol_q   <= RXPOL_INIT;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rxpol_q   <= rxpol_d;
    end
  end

  assign link.RXPOL = rxpol_q;
`else
  assign link.RXPOL = RXPOL_INIT;
`endif

  assign link.rx_data       = rx_data_q;
  assign link.rx_word_valid = rx_valid_q;
  assign link.sync          = sync_q;
  assign link.tx_ready      = tx_ready_c;
  assign link.tx_load       = tx_load_q;
  assign link.tx_word       = tx_word_q;

endmodule

// File: tb/tb_serdes_link_ctrl.sv
// Randomized bench for serdes_link_ctrl: cycle-level reference model keyed on the comma anchor
// cycle, compared every cycle, plus directed checks with hand-derived literal expectations.
module tb_serdes_link_ctrl;
  localparam logic [9:0] COMMA = 10'b0011111010;

  logic clk = 1'b0;
  logic rst, en;
  serdes_link_ctrl_if link();

  serdes_link_ctrl dut (
    .TRANSCLK (clk),
    .RESET    (rst),
    .ENABLE   (en),
    .link     (link)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 hunting, 1 verifying, 2 synced; boundaries are every 10th cycle
  // counted from the cycle where the acquiring comma was seen.
  bit         model_on = 1'b0;
  int         mode, lockn, errn, tmo, anchor, cyc, txk;
  logic       exp_sync, exp_valid, exp_tx_load, exp_rxpol;
  logic [9:0] exp_rx_data, exp_tx_word;

  task automatic model_step();
    bit comma, bnd;
    if (rst) begin
      model_on = 1'b1;
      mode = 0; lockn = 0; errn = 0; tmo = 0; anchor = 0; cyc = 0; txk = 0;
      exp_sync = 1'b0; exp_valid = 1'b0; exp_tx_load = 1'b0; exp_rxpol = 1'b1;
      exp_rx_data = '0; exp_tx_word = COMMA;
      return;
    end
    if (!model_on) return;
    if (txk == 9) begin
      exp_tx_word = (link.tx_valid && exp_sync) ? link.tx_data : COMMA;
      exp_tx_load = 1'b1;
    end else begin
      exp_tx_load = 1'b0;
    end
    txk = (txk + 1) % 10;
    comma = (link.rx_word == COMMA);
    bnd   = (mode != 0) && ((cyc - anchor) % 10 == 0);
    exp_valid = (mode == 2) && bnd;
    if (exp_valid) exp_rx_data = link.rx_word;
    if (!en) begin
      mode = 0; lockn = 0; errn = 0; tmo = 0;
    end else if (mode == 0) begin
      if (comma) begin
        mode = 1; anchor = cyc; lockn = 1; tmo = 0;
      end else begin
        tmo++;
        if (tmo == 1023) begin
          tmo = 0;
`ifdef SERDES_AUTOPOL_EN
          exp_rxpol = ~exp_rxpol;
`endif
        end
      end
    end else if (mode == 1) begin
      if (bnd && comma) begin
        lockn++;
        if (lockn >= 4) mode = 2;
      end else if (bnd || comma) begin
        mode = 0; lockn = 0;
      end
    end else begin
      if (comma && bnd) errn = 0;
      else if (comma) begin
        errn++;
        if (errn >= 4) begin mode = 0; errn = 0; lockn = 0; end
      end
    end
    exp_sync = (mode == 2);
    cyc++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
      if (model_on) begin
        check("sync",          32'(link.sync),          32'(exp_sync));
        check("rx_word_valid", 32'(link.rx_word_valid), 32'(exp_valid));
        check("rx_data",       32'(link.rx_data),       32'(exp_rx_data));
        check("tx_load",       32'(link.tx_load),       32'(exp_tx_load));
        check("tx_word",       32'(link.tx_word),       32'(exp_tx_word));
        check("tx_ready",      32'(link.tx_ready),      32'((txk == 9) && exp_sync));
        check("RXPOL",         32'(link.RXPOL),         32'(exp_rxpol));
      end
    end
  end

  // Stimulus generator: commas every 10 cycles at offset g_off, plus optional faults
  int gcyc = 0;
  int g_off = 0;
  bit g_commas = 1'b0;
  int g_badbnd_pct = 0;
  int g_stray_pct = 0;
  bit g_tx_rand = 1'b0;

  function automatic logic [9:0] noncomma();
    logic [9:0] w;
    w = 10'($urandom);
    while (w == COMMA) w = 10'($urandom);
    return w;
  endfunction

  task automatic cycle();
    bit bnd;
    @(negedge clk);
    #1;
    gcyc++;
    bnd = (((gcyc - g_off) % 10) + 10) % 10 == 0;
    if (bnd && g_commas && ($urandom_range(0, 99) >= g_badbnd_pct)) link.rx_word = COMMA;
    else if ($urandom_range(0, 99) < g_stray_pct) link.rx_word = COMMA;
    else link.rx_word = noncomma();
    if (g_tx_rand) begin
      link.tx_valid = 1'($urandom);
      link.tx_data  = 10'($urandom);
    end
  endtask

  int n, m;

  initial begin
    rst = 1'b1; en = 1'b1;
    link.rx_word = 10'h000; link.tx_data = 10'h000; link.tx_valid = 1'b0;
    cycle(); cycle();
    check("rst_sync",    32'(link.sync),          32'h0);
    check("rst_valid",   32'(link.rx_word_valid), 32'h0);
    check("rst_rx_data", 32'(link.rx_data),       32'h0);
    check("rst_tx_load", 32'(link.tx_load),       32'h0);
    check("rst_tx_word", 32'(link.tx_word),       32'(COMMA));
    check("rst_RXPOL",   32'(link.RXPOL),         32'h1);

    // Aligned commas: acquire at e0, lock on the 3rd following boundary
    rst = 1'b0;
    g_commas = 1'b1;
    g_off = gcyc + 1;
    cycle();
    n = 0;
    do begin cycle(); n++; end while (!link.sync && n < 100);
    check("lock_latency", 32'(n), 32'd31);

    // TX user data only in the phase-9 slot while synced
    link.tx_valid = 1'b1; link.tx_data = 10'h2AA;
    n = 0;
    do begin cycle(); n++; end while (!link.tx_load && n < 30);
    check("tx_user_word", 32'(link.tx_word), 32'h2AA);
    link.tx_valid = 1'b0;
    n = 0;
    do begin cycle(); n++; end while (!link.tx_load && n < 30);
    check("tx_idle_comma", 32'(link.tx_word), 32'(COMMA));

    // Shift the RX stream by 3: 4 misaligned commas drop sync, relock 40 cycles later
    g_off += 3;
    n = 0;
    do begin cycle(); n++; end while (link.sync && n < 100);
    check("loss_sync", 32'(link.sync), 32'h0);
    m = 0;
    do begin cycle(); m++; end while (!link.sync && m < 100);
    check("relock_latency", 32'(m), 32'd40);

    // VERIFY, then a data word at the boundary: back to HUNT, never synced
    en = 1'b0;
    cycle(); cycle();
    en = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (link.rx_word != COMMA && n < 20);
    g_commas = 1'b0;
    repeat (40) cycle();
    check("verify_fail_sync", 32'(link.sync), 32'h0);
    g_commas = 1'b1;
    repeat (60) cycle();
    check("resync", 32'(link.sync), 32'h1);

    // Reset in SYNC with user traffic
    link.tx_valid = 1'b1; link.tx_data = 10'h155;
    repeat (12) cycle();
    rst = 1'b1;
    cycle();
    check("midrst_sync",    32'(link.sync),          32'h0);
    check("midrst_valid",   32'(link.rx_word_valid), 32'h0);
    check("midrst_tx_word", 32'(link.tx_word),       32'(COMMA));
    check("midrst_RXPOL",   32'(link.RXPOL),         32'h1);
    rst = 1'b0;
    link.tx_valid = 1'b0;

`ifdef SERDES_AUTOPOL_EN
    g_commas = 1'b0;
    repeat (1030) cycle();
    check("autopol_flip", 32'(link.RXPOL), 32'h0);
    g_commas = 1'b1;
`endif

    // Randomized soak
    g_tx_rand = 1'b1;
    g_stray_pct = 2;
    g_badbnd_pct = 8;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) g_off += int'($urandom_range(1, 9));
      en  = ($urandom_range(0, 399) != 0);
      rst = ($urandom_range(0, 1499) == 0);
      cycle();
    end
    rst = 1'b0; en = 1'b1;
    cycle(); cycle();

`ifndef SERDES_AUTOPOL_EN
    check("rxpol_constant", 32'(link.RXPOL), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
